// File: rtl/dp_mem_responder.sv
// Memory-side responder: serialises datapath fetch/data requests onto a single-ported RAM,
// with data priority, one-cycle hit pulses and a no-ack timeout.
module dp_mem_responder #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hBAD0_BAD0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramack,
  output logic        memerr
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StDacc, StIfetch, StResp} state_e;
  typedef enum logic {SrcInstr, SrcData} src_e;

  state_e          state_q, state_d;
  src_e            src_q, src_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;
  logic [31:0]     load_q, load_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            memerr_q, memerr_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      src_q    <= SrcInstr;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      load_q   <= '0;
      tcnt_q   <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      load_q   <= load_d;
      tcnt_q   <= tcnt_d;
      memerr_q <= memerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    store_d  = store_q;
    load_d   = load_q;
    tcnt_d   = tcnt_q;
    memerr_d = memerr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ihit     = 1'b0;
    dhit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dmemWEN || dmemREN) begin
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
          src_d   = SrcData;
          tcnt_d  = '0;
          state_d = StDacc;
        end else if (imemREN && !halt) begin
          addr_d  = imemaddr;
          wr_d    = 1'b0;
          src_d   = SrcInstr;
          tcnt_d  = '0;
          state_d = StIfetch;
        end
      end
      StDacc, StIfetch: begin
        ramWEN = wr_q;
        ramREN = !wr_q;
        if (ramack) begin
          if (!wr_q) load_d = ramload;
          state_d = StResp;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Abandon the access; reads return a recognisable poison value.
          if (!wr_q) load_d = ERR_DATA;
          memerr_d = 1'b1;
          state_d  = StResp;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StResp: begin
        ihit    = (src_q == SrcInstr);
        dhit    = (src_q == SrcData);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign imemload = load_q;
  assign dmemload = load_q;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed table-driven bench for dp_mem_responder (TIMEOUT=4), plus hand-written
// halt and mid-access reset sequences.
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN, halt, ramack;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, memerr;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  dp_mem_responder #(.TIMEOUT(4), .ERR_DATA(32'hBAD0_BAD0)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramack(ramack), .memerr(memerr)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] ds;
    logic        ack;
    logic [31:0] rl;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_ih;
    logic        e_dh;
    logic        chk;
    logic [31:0] e_load;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds, input logic ack,
                     input logic [31:0] rl, input logic e_ren, input logic e_wen,
                     input logic [31:0] e_addr, input logic [31:0] e_store, input logic e_ih,
                     input logic e_dh, input logic chk, input logic [31:0] e_load,
                     input logic e_err);
    vec_t v;
    v = '{ir, ia, dr, dw, da, ds, ack, rl, e_ren, e_wen, e_addr, e_store, e_ih, e_dh, chk,
          e_load, e_err};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0; ramack = 0;
    imemaddr = 0; dmemaddr = 0; dmemstore = 0; ramload = 0;

    // Fetch: ack in cycle 3, ihit in cycle 4
    add(1, 'h40, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h40, 0, 0, 0, 0, 0, 0,            1, 0, 'h40, 0, 0, 0, 0, 0, 0);
    add(1, 'h40, 0, 0, 0, 0, 0, 0,            1, 0, 'h40, 0, 0, 0, 0, 0, 0);
    add(1, 'h40, 0, 0, 0, 0, 1, 'h8C220004,   1, 0, 'h40, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 1, 0, 1, 'h8C220004, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Priority: data first, one idle cycle, then the fetch
    add(1, 'h44, 1, 0, 'h100, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h44, 1, 0, 'h100, 0, 1, 'h1234,   1, 0, 'h100, 0, 0, 0, 0, 0, 0);
    add(1, 'h44, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 'h1234, 0);
    add(1, 'h44, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h44, 0, 0, 0, 0, 1, 'h5555,       1, 0, 'h44, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 1, 0, 1, 'h5555, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Write wins over read when both strobes are high
    add(0, 0, 1, 1, 'h200, 'hCAFEF00D, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 'h200, 'hCAFEF00D, 1, 'hDEAD, 0, 1, 'h200, 'hCAFEF00D, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Timeout: 4 strobe cycles, dhit in cycle 5 with ERR_DATA, memerr sticky
    add(0, 0, 1, 0, 'h300, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 0, 'h300, 0, 0, 0,         1, 0, 'h300, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1, 1, 'hBAD0BAD0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 'h304, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 'h304, 0, 1, 'h77,        1, 0, 'h304, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1, 1, 'h77, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 1);

    #2;
    check("rst ramREN", ramREN, 0);
    check("rst ramWEN", ramWEN, 0);
    check("rst ramaddr", ramaddr, 0);
    check("rst ramstore", ramstore, 0);
    check("rst imemload", imemload, 0);
    check("rst dmemload", dmemload, 0);
    check("rst memerr", memerr, 0);
    check("rst hits", {ihit, dhit}, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      imemREN = v.ir; imemaddr = v.ia; dmemREN = v.dr; dmemWEN = v.dw;
      dmemaddr = v.da; dmemstore = v.ds; ramack = v.ack; ramload = v.rl;
      #1;
      check($sformatf("v%0d ramREN", i), ramREN, v.e_ren);
      check($sformatf("v%0d ramWEN", i), ramWEN, v.e_wen);
      check($sformatf("v%0d ihit", i), ihit, v.e_ih);
      check($sformatf("v%0d dhit", i), dhit, v.e_dh);
      check($sformatf("v%0d memerr", i), memerr, v.e_err);
      if (v.e_ren || v.e_wen) check($sformatf("v%0d ramaddr", i), ramaddr, v.e_addr);
      if (v.e_wen) check($sformatf("v%0d ramstore", i), ramstore, v.e_store);
      if (v.chk && v.e_ih) check($sformatf("v%0d imemload", i), imemload, v.e_load);
      if (v.chk && v.e_dh) check($sformatf("v%0d dmemload", i), dmemload, v.e_load);
      next_cycle();
    end

    // Halt: fetch blocked for 20 cycles; a data read raised in cycle 5 is still served
    for (int i = 0; i < 20; i++) begin
      halt = 1; imemREN = 1; imemaddr = 'h500; ramack = 1; ramload = 'hABCD;
      dmemREN = (i == 5 || i == 6); dmemWEN = 0; dmemaddr = 'h400;
      #1;
      check($sformatf("halt%0d ramREN", i), ramREN, (i == 6));
      check($sformatf("halt%0d ihit", i), ihit, 0);
      check($sformatf("halt%0d dhit", i), dhit, (i == 7));
      if (i == 6) check("halt ramaddr", ramaddr, 'h400);
      if (i == 7) check("halt dmemload", dmemload, 'hABCD);
      next_cycle();
    end
    halt = 0; imemREN = 0; dmemREN = 0; ramack = 0;
    next_cycle();

    // Reset in the middle of a fetch
    imemREN = 1; imemaddr = 'h80;
    next_cycle();
    check("mid ramREN before rst", ramREN, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("mid ramREN async drop", ramREN, 0);
    imemREN = 0;
    repeat (2) begin
      next_cycle();
      check("mid ihit in rst", ihit, 0);
    end
    check("mid memerr cleared", memerr, 0);
    @(negedge CLK);
    nRST = 1'b1;
    next_cycle();
    imemREN = 1; imemaddr = 'h84; ramack = 1; ramload = 'h99;
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        next_cycle();
        if (ihit) got = 1;
      end
      check("post-rst ihit seen", got, 1);
      check("post-rst imemload", imemload, 'h99);
    end
    imemREN = 0; ramack = 0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the datapath's cache interface. It accepts instruction-fetch and data-access requests from the datapath and serialises them onto a single-ported RAM with a request/acknowledge handshake. It returns `ihit`/`dhit` pulses with registered load data. Data accesses take priority over fetches, and a timeout guards against a RAM that never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum number of cycles in an access state without `ramack` before the access is abandoned.
- `ERR_DATA`, default 32'hBAD0_BAD0: load value returned on a timed-out read.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  instruction-fetch request.
- `imemaddr`  in  32  fetch address (word address; bits [1:0] are forwarded unchanged).
- `imemload`  out  32  fetched instruction; valid while `ihit`=1.
- `ihit`  out  1  one-cycle fetch-complete pulse.
- `dmemREN`  in  1  data read request.
- `dmemWEN`  in  1  data write request.
- `dmemaddr`  in  32  data address.
- `dmemstore`  in  32  write data.
- `dmemload`  out  32  read data; valid while `dhit`=1.
- `dhit`  out  1  one-cycle data-complete pulse (reads and writes).
- `halt`  in  1  datapath halted; blocks new fetches.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data; sampled in the cycle `ramack`=1.
- `ramack`  in  1  RAM completion; may be held high, but only the first cycle counts per access.
- `memerr`  out  1  sticky timeout flag.

## Operation
The block is a four-state FSM: IDLE, DACC, IFETCH, RESP.

**IDLE**
- All RAM strobes are 0.
- If `dmemWEN` or `dmemREN`: latch `dmemaddr` and `dmemstore` into the address/store registers.
  - Latch the access type: write if `dmemWEN`=1. WEN has precedence when both strobes are high.
  - Set `src`=DATA and go to DACC.
- Else if `imemREN` and not `halt`: latch `imemaddr`, set `src`=INSTR and go to IFETCH.
- Else stay in IDLE.

**DACC / IFETCH**
- Drive `ramaddr` and `ramstore` from the latched registers.
- `ramWEN`=1 only for a data write; otherwise `ramREN`=1.
- Timeout counter `tcnt` is cleared on entry and increments every cycle without `ramack`.
- On `ramack`: capture `ramload` into the load register (reads only) and go to RESP.
- When `tcnt` reaches TIMEOUT-1 without `ramack`:
  - load register ← ERR_DATA (reads only); set `memerr`; go to RESP.
- Request inputs are ignored while in these states. The address is latched, so datapath input changes have no effect.

**RESP**
- Strobes are 0.
- Assert `ihit` (if `src`=INSTR) or `dhit` (if `src`=DATA) for exactly one cycle.
- `imemload`/`dmemload` present the load register.
- Next state is always IDLE, so back-to-back requests have one IDLE cycle between accesses.

**Outputs outside RESP**
- `ihit`=`dhit`=0.
- `imemload`/`dmemload` hold their last value; they are not required to be meaningful.

**Halt**
- `halt` does not abort an in-progress fetch.
- Data requests are still served while halted.

**Arithmetic**
- `tcnt` width is clog2(TIMEOUT)+1 and it never wraps.
- `memerr` is cleared only by reset.

## Timing
- Reset values: state IDLE; `ihit`, `dhit`, `ramREN`, `ramWEN`, `memerr` = 0; `ramaddr`, `ramstore`, `imemload`, `dmemload` = 0; `tcnt`=0.
- Reset asserted in any state forces IDLE immediately. Strobes drop asynchronously, and no hit is issued for the aborted access.
- Latency, with the request sampled in IDLE at edge 0:
  - strobe asserted in cycle 1;
  - if `ramack` arrives in cycle k (k≥1), the hit pulse is in cycle k+1;
  - minimum request-to-hit latency is 2 cycles.
- Timeout: with no ack, strobes stay high for cycles 1..TIMEOUT and the hit occurs in cycle TIMEOUT+1.
- Simultaneous fetch and data requests: data is served first. The fetch is taken from IDLE the cycle after `dhit`, provided `imemREN` is still high.
- The datapath must hold a request until its hit. The block never issues a hit without a prior request accepted in IDLE.
- Read data captured on `ramack` is stable from the RESP cycle until the next RESP.

## Test plan
1. **Fetch.** After reset, `imemREN`=1, `imemaddr`=0x40; RAM acks in cycle 3 with 0x8C220004 → `ramREN`=1 in cycles 1–3, `ramaddr`=0x40, `ihit`=1 only in cycle 4, `imemload`=0x8C220004.
2. **Priority.** `imemREN`=1 and `dmemREN`=1 (addr 0x100) in the same cycle, RAM acks immediately with 0x1234 → `dhit` first with `dmemload`=0x1234, then IDLE, then fetch, then `ihit`.
3. **Write.** `dmemWEN`=1 and `dmemREN`=1, addr 0x200, store 0xCAFEF00D → `ramWEN`=1 and `ramREN`=0, `ramstore`=0xCAFEF00D, then `dhit` for one cycle.
4. **Timeout.** Read with `ramack` held at 0, TIMEOUT=4 → strobe high for 4 cycles, `dhit` in cycle 5 with `dmemload`=0xBAD0BAD0, `memerr`=1 and staying at 1 across later good accesses.
5. **Halt.** `halt`=1 with `imemREN`=1 → no `ramREN`, no `ihit` for 20 cycles. A `dmemREN` issued in the same window is still served.
6. **Reset mid-access.** `nRST` pulsed low while in IFETCH → `ramREN` drops immediately, no `ihit`. After release, a new request completes normally.
